// File: rtl/arbitro_rr.sv
// arbitro_rr: round-robin arbiter/router between four input FIFOs and four
// output FIFOs. Pops one word from a granted non-empty input FIFO, captures it
// one cycle later, then pushes it to the output FIFO selected by word[MSB:MSB-1].
//
// Ports:
//   clk, reset_L        single clock, synchronous active-low reset
//   fifo_empty_in[3:0]  empty flags of input FIFOs 0..3
//   data_in0..3         read data of input FIFOs 0..3 (valid the cycle after pop)
//   pausa_in[3:0]       back-pressure flags of output FIFOs (checked at grant only)
//   fifo_full_in[3:0]   full flags of output FIFOs (checked in PUSH)
//   pop_out[3:0]        one-hot pop to input FIFOs (registered)
//   push_out[3:0]       one-hot push to output FIFOs (registered)
//   data_out            word presented with push_out, holds last pushed word
//   error_o             sticky push-while-full flag
//   cnt_out[7:0]        number of pushes, wraps modulo 256
module arbitro_rr #(
  parameter int unsigned DATA_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [3:0]            fifo_empty_in,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  input  logic [3:0]            pausa_in,
  input  logic [3:0]            fifo_full_in,
  output logic [3:0]            pop_out,
  output logic [3:0]            push_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  error_o,
  output logic [7:0]            cnt_out
);

  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned PTR_W     = 2;
  localparam int unsigned CNT_W     = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_POP  = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;
  localparam logic [1:0] ST_PUSH = 2'd3;

  logic [1:0]            state_q,  state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0]  pop_q,    pop_d;
  logic [NUM_PORTS-1:0]  push_q,   push_d;
  logic [DATA_WIDTH-1:0] data_q,   data_d;
  logic                  error_q,  error_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;

  logic                  grant_ok_c;
  logic [PTR_W-1:0]      gnt_idx_c;
  logic [PTR_W-1:0]      cand_c;
  logic [DATA_WIDTH-1:0] capt_word_c;

  function automatic logic [NUM_PORTS-1:0] onehot(input logic [PTR_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Grant allowed only with no back-pressure and at least one non-empty source
  assign grant_ok_c = (pausa_in == 4'b0000) && (fifo_empty_in != 4'b1111);

  // First non-empty FIFO scanning from rr_ptr+1 upward, wrapping modulo 4
  always_comb begin : grant_sel
    gnt_idx_c = rr_ptr_q;
    cand_c    = rr_ptr_q;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand_c = rr_ptr_q + PTR_W'(k);
      if (!fifo_empty_in[cand_c]) begin
        gnt_idx_c = cand_c;
      end
    end
  end

  // rr_ptr still holds the granted index while in CAPT
  always_comb begin : capt_mux
    case (rr_ptr_q)
      2'd0:    capt_word_c = data_in0;
      2'd1:    capt_word_c = data_in1;
      2'd2:    capt_word_c = data_in2;
      default: capt_word_c = data_in3;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin : fsm_next
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    pop_d    = '0;
    push_d   = '0;
    data_d   = data_q;
    error_d  = error_q;
    cnt_d    = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_ok_c) begin
          state_d  = ST_POP;
          pop_d    = onehot(gnt_idx_c);
          rr_ptr_d = gnt_idx_c;
        end
      end
      ST_POP: begin
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        state_d = ST_PUSH;
        data_d  = capt_word_c;
        push_d  = onehot(capt_word_c[DATA_WIDTH-1 -: PTR_W]);
      end
      ST_PUSH: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (fifo_full_in[data_q[DATA_WIDTH-1 -: PTR_W]]) begin
          error_d = 1'b1;
        end
        // Re-arbitrate in the push cycle so back-to-back transfers take 3 cycles
        if (grant_ok_c) begin
          state_d  = ST_POP;
          pop_d    = onehot(gnt_idx_c);
          rr_ptr_d = gnt_idx_c;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin : regs
    if (!reset_L) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= PTR_W'(3);
      pop_q    <= '0;
      push_q   <= '0;
      data_q   <= '0;
      error_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      pop_q    <= pop_d;
      push_q   <= push_d;
      data_q   <= data_d;
      error_q  <= error_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pop_out  = pop_q;
  assign push_out = push_q;
  assign data_out = data_q;
  assign error_o  = error_q;
  assign cnt_out  = cnt_q;

endmodule

// File: tb/tb_arbitro_rr.sv
// tb_arbitro_rr: randomized and directed stimulus for arbitro_rr, checked every
// cycle against a transaction-timing reference model plus scenario checks.
module tb_arbitro_rr;

  localparam int unsigned DW = 6;

  logic          clk = 1'b0;
  logic          reset_L;
  logic [3:0]    fifo_empty_in;
  logic [3:0]    pausa_in;
  logic [3:0]    fifo_full_in;
  logic [DW-1:0] din [4];
  logic [3:0]    pop_out;
  logic [3:0]    push_out;
  logic [DW-1:0] data_out;
  logic          error_o;
  logic [7:0]    cnt_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  arbitro_rr #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .fifo_empty_in(fifo_empty_in),
    .data_in0     (din[0]),
    .data_in1     (din[1]),
    .data_in2     (din[2]),
    .data_in3     (din[3]),
    .pausa_in     (pausa_in),
    .fifo_full_in (fifo_full_in),
    .pop_out      (pop_out),
    .push_out     (push_out),
    .data_out     (data_out),
    .error_o      (error_o),
    .cnt_out      (cnt_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A transfer granted in cycle tg pops in tg+1, captures the source data in
  // tg+2, pushes in tg+3; arbitration resumes in tg+3.
  logic [3:0]    e_pop, e_push, n_pop, n_push;
  logic [DW-1:0] e_data, cap;
  logic          e_err;
  logic [7:0]    e_cnt;
  int            m_rr, m_g, m_tg, m_idx;
  bit            m_busy  = 1'b0;
  bit            m_valid = 1'b0;
  bit            found;

  int pop_cnt  = 0;
  int push_cnt = 0;
  bit rec_en   = 1'b0;
  int rec_idx[$];
  int rec_cyc[$];

  always @(negedge clk) begin
    if (m_valid) begin
      chk("pop",  32'(pop_out),  32'(e_pop));
      chk("push", 32'(push_out), 32'(e_push));
      chk("data", 32'(data_out), 32'(e_data));
      chk("err",  32'(error_o),  32'(e_err));
      chk("cnt",  32'(cnt_out),  32'(e_cnt));
      if (pop_out != 4'b0000) begin
        pop_cnt++;
        if (rec_en) begin
          rec_idx.push_back($clog2(pop_out));
          rec_cyc.push_back(cyc);
        end
      end
      if (push_out != 4'b0000) push_cnt++;
    end

    if (!reset_L) begin
      e_pop = '0; e_push = '0; e_data = '0; e_err = 1'b0; e_cnt = '0;
      m_rr = 3; m_busy = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      n_pop  = '0;
      n_push = '0;
      if (m_busy && cyc == m_tg + 2) begin
        cap    = din[m_g];
        n_push = 4'b0001 << cap[DW-1 -: 2];
        e_data = cap;
      end
      if (m_busy && cyc == m_tg + 3) begin
        if (fifo_full_in[e_data[DW-1 -: 2]]) e_err = 1'b1;
        e_cnt  = e_cnt + 8'd1;
        m_busy = 1'b0;
      end
      if (!m_busy && pausa_in == 4'b0000 && fifo_empty_in != 4'b1111) begin
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          m_idx = (m_rr + k) % 4;
          if (!found && !fifo_empty_in[m_idx]) begin
            found = 1'b1;
            m_g   = m_idx;
          end
        end
        m_rr   = m_g;
        m_tg   = cyc;
        m_busy = 1'b1;
        n_pop  = 4'b0001 << m_g;
      end
      e_pop  = n_pop;
      e_push = n_push;
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < 4; i++) din[i] = DW'($urandom);
  endtask

  task automatic apply_reset(input int n);
    reset_L = 1'b0;
    repeat (n) tick();
    reset_L = 1'b1;
  endtask

  task automatic wait_pop(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      tick();
      if (pop_out != 4'b0000) ok = 1'b1;
    end
  endtask

  int p0, q0;
  bit ok;

  initial begin
    // Reset with random inputs
    reset_L       = 1'b0;
    fifo_empty_in = 4'($urandom);
    pausa_in      = 4'($urandom);
    fifo_full_in  = 4'($urandom);
    rand_data();
    repeat (2) begin
      tick();
      fifo_empty_in = 4'($urandom);
      pausa_in      = 4'($urandom);
      fifo_full_in  = 4'($urandom);
      rand_data();
    end
    chk("rst_pop",  32'(pop_out),  32'h0);
    chk("rst_push", 32'(push_out), 32'h0);
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_err",  32'(error_o),  32'h0);
    chk("rst_cnt",  32'(cnt_out),  32'h0);

    // Single word from FIFO1, destination class 2'b10
    reset_L       = 1'b1;
    fifo_empty_in = 4'b1101;
    pausa_in      = 4'b0000;
    fifo_full_in  = 4'b0000;
    din[1]        = 6'b101010;
    p0 = pop_cnt; q0 = push_cnt;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (pop_out[1]) fifo_empty_in = 4'b1111;
      if (push_out != 4'b0000) begin
        chk("single_push", 32'(push_out), 32'h4);
        chk("single_data", 32'(data_out), 32'h2A);
      end
    end
    chk("single_pops",   32'(pop_cnt - p0),  32'd1);
    chk("single_pushes", 32'(push_cnt - q0), 32'd1);
    chk("single_cnt",    32'(cnt_out),       32'd1);

    // Round-robin with all sources non-empty
    apply_reset(1);
    fifo_empty_in = 4'b0000;
    rec_idx.delete();
    rec_cyc.delete();
    rec_en = 1'b1;
    repeat (22) begin
      tick();
      rand_data();
    end
    rec_en = 1'b0;
    chk("rr_count", 32'(rec_idx.size() >= 6), 32'd1);
    for (int k = 0; k < 6 && k < rec_idx.size(); k++) begin
      chk("rr_idx", 32'(rec_idx[k]), 32'(k % 4));
      if (k > 0) chk("rr_gap", 32'(rec_cyc[k] - rec_cyc[k-1]), 32'd3);
    end

    // Back-pressure raised during a POP cycle
    wait_pop(10, ok);
    chk("bp_wait", 32'(ok), 32'd1);
    pausa_in = 4'b1000;
    tick();
    p0 = pop_cnt;
    repeat (8) begin
      tick();
      rand_data();
    end
    chk("bp_nopop", 32'(pop_cnt - p0), 32'd0);
    pausa_in = 4'b0000;
    wait_pop(4, ok);
    chk("bp_resume", 32'(ok), 32'd1);

    // Push into a full output FIFO sets the sticky error
    fifo_empty_in = 4'b1111;
    apply_reset(1);
    fifo_empty_in = 4'b1110;
    din[0]        = {2'b11, 4'($urandom)};
    fifo_full_in  = 4'b1000;
    wait_pop(5, ok);
    chk("err_wait", 32'(ok), 32'd1);
    fifo_empty_in = 4'b1111;
    tick();
    tick();
    chk("err_push", 32'(push_out), 32'h8);
    tick();
    chk("err_set", 32'(error_o), 32'd1);
    fifo_full_in = 4'b0000;
    repeat (5) tick();
    chk("err_sticky", 32'(error_o), 32'd1);

    // Reset during CAPT drops the word; next grant restarts at FIFO0
    fifo_empty_in = 4'b0000;
    wait_pop(10, ok);
    chk("midrst_wait", 32'(ok), 32'd1);
    tick();
    q0 = push_cnt;
    reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
    wait_pop(6, ok);
    chk("midrst_pop",    32'(ok),            32'd1);
    chk("midrst_first",  32'(pop_out),       32'h1);
    chk("midrst_nopush", 32'(push_cnt - q0), 32'd0);

    // Random traffic with occasional pauses, full flags and resets
    for (int i = 0; i < 1500; i++) begin
      tick();
      fifo_empty_in = 4'($urandom);
      pausa_in      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      fifo_full_in  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
      reset_L       = ($urandom_range(0, 99) != 0);
      rand_data();
    end
    reset_L = 1'b1;

    // 256 pushes wrap the counter back to zero
    apply_reset(1);
    fifo_empty_in = 4'b0000;
    pausa_in      = 4'b0000;
    fifo_full_in  = 4'b0000;
    q0 = push_cnt;
    for (int i = 0; i < 1000 && (push_cnt - q0) < 256; i++) begin
      tick();
      rand_data();
    end
    chk("wrap_pushes", 32'(push_cnt - q0), 32'd256);
    chk("wrap_cnt",    32'(cnt_out),       32'd0);

    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
